// File: rtl/fetch_queue.sv
// Prefetching instruction-fetch unit: keeps a pipelined instruction-memory port busy
// and hands instructions to decode in order through a small queue; redirects flush it.
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned MAX_OUT  = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] instruction,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic        BranchSignal,
  input  logic        BranchCondition,
  input  logic        Jump,
  input  logic [15:0] imm16,
  input  logic [25:0] target
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned OUT_W = $clog2(MAX_OUT + 1);
  localparam logic [OUT_W-1:0] MAX_OUT_V = OUT_W'(MAX_OUT);
  localparam logic [CNT_W:0]   DEPTH_V   = (CNT_W + 1)'(DEPTH);

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      resp_pc_q, resp_pc_d;
  logic [31:0]      data_q [DEPTH];
  logic [31:0]      data_d [DEPTH];
  logic [31:0]      pc_q [DEPTH];
  logic [31:0]      pc_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [OUT_W-1:0] outstanding_q, outstanding_d;
  logic [OUT_W-1:0] drop_q, drop_d;

  logic             fire, rsp, enq, consume, redirect;
  logic [OUT_W-1:0] in_flight;
  logic [CNT_W:0]   credit_used;
  logic [31:0]      pc_plus4, redir_target;

  // Credits cover queued entries plus responses that will still be enqueued.
  always_comb begin
    in_flight   = outstanding_q - drop_q;
    credit_used = {1'b0, count_q} + {{(CNT_W + 1 - OUT_W){1'b0}}, in_flight};
    imem_req    = !rst && (outstanding_q < MAX_OUT_V) && (credit_used < DEPTH_V);
    imem_addr   = fetch_pc_q;
    inst_valid  = (count_q != '0);
    instruction = inst_valid ? data_q[rd_ptr_q] : '0;
    inst_pc     = inst_valid ? pc_q[rd_ptr_q] : '0;
  end

  always_comb begin
    fire     = imem_req && imem_gnt;
    rsp      = imem_rvalid && (outstanding_q != '0);
    consume  = inst_valid && inst_ready;
    redirect = consume && (Jump || (BranchSignal && BranchCondition));
    pc_plus4 = inst_pc + 32'd4;
    if (Jump) redir_target = {pc_plus4[31:28], target, 2'b00};
    else      redir_target = pc_plus4 + {{14{imm16[15]}}, imm16, 2'b00};
    enq      = rsp && (drop_q == '0) && !redirect;
  end

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    data_d        = data_q;
    pc_d          = pc_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    drop_d        = drop_q;
    outstanding_d = outstanding_q + OUT_W'(fire) - OUT_W'(rsp);
    count_d       = count_q + CNT_W'(enq) - CNT_W'(consume);
    if (fire) fetch_pc_d = fetch_pc_q + 32'd4;
    if (rsp && (drop_q != '0)) drop_d = drop_q - OUT_W'(1);
    if (enq) begin
      data_d[wr_ptr_q] = imem_rdata;
      pc_d[wr_ptr_q]   = resp_pc_q;
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
      resp_pc_d        = resp_pc_q + 32'd4;
    end
    if (consume) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    // Everything still in flight after this cycle belongs to the old stream.
    if (redirect) begin
      count_d    = '0;
      rd_ptr_d   = wr_ptr_q;
      fetch_pc_d = redir_target;
      resp_pc_d  = redir_target;
      drop_d     = outstanding_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      outstanding_q <= '0;
      drop_q        <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    data_q <= data_d;
    pc_q   <= pc_d;
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: random in-order variable-latency memory, random decode
// handshakes and redirects, checked against an architectural program-order PC model.
module tb_fetch_queue;

  localparam int unsigned DEPTH    = 4;
  localparam int unsigned MAX_OUT  = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  logic        clk, rst;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        inst_valid, inst_ready;
  logic [31:0] instruction, inst_pc;
  logic        BranchSignal, BranchCondition, Jump;
  logic [15:0] imm16;
  logic [25:0] target;

  fetch_queue #(.DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .instruction(instruction), .inst_pc(inst_pc),
    .inst_ready(inst_ready), .BranchSignal(BranchSignal),
    .BranchCondition(BranchCondition), .Jump(Jump), .imm16(imm16), .target(target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned errors = 0;
  int unsigned checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // Program-order successor of an instruction at pc given its decode outcome.
  function automatic logic [31:0] next_pc(input logic [31:0] pc, input logic br, input logic cond,
                                          input logic jmp, input logic [15:0] imm, input logic [25:0] tgt);
    logic [31:0] seq;
    int          off;
    seq = pc + 32'd4;
    off = $signed(imm);
    if (jmp) return {seq[31:28], tgt, 2'b00};
    if (br && cond) return seq + 32'(off * 4);
    return seq;
  endfunction

  // ---------------- memory model ----------------
  typedef struct {
    logic [31:0] addr;
    int unsigned due;
  } req_t;

  req_t        pend[$];
  int unsigned cyc = 0, last_due = 0, fire_cnt = 0;
  int unsigned lat_min = 1, lat_max = 1, gnt_pct = 100;
  logic        force_spur = 1'b0;
  logic        hold_v = 1'b0;
  logic [31:0] hold_a;

  always @(posedge clk) begin
    cyc++;
    #1;
    imem_gnt = ($urandom_range(99, 0) < gnt_pct);
    if (force_spur) begin
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hDEAD_BEEF;
    end else if (pend.size() != 0 && pend[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(pend[0].addr);
      void'(pend.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      pend.delete();
      last_due = 0;
      fire_cnt = 0;
      hold_v   = 1'b0;
    end else begin
      if (hold_v && imem_req) check("addr_hold", imem_addr, hold_a);
      hold_v = imem_req && !imem_gnt &&
               !(inst_valid && inst_ready && (Jump || (BranchSignal && BranchCondition)));
      hold_a = imem_addr;
      if (imem_req && imem_gnt) begin
        req_t r;
        int unsigned d;
        d = cyc + $urandom_range(lat_max, lat_min);
        if (d <= last_due) d = last_due + 1;
        last_due = d;
        r.addr = imem_addr;
        r.due  = d;
        pend.push_back(r);
        fire_cnt++;
        checks++;
        if (pend.size() > MAX_OUT) begin
          errors++;
          $display("FAIL max_outstanding: got %0d expected <= %0d", pend.size(), MAX_OUT);
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  logic [31:0] model_pc;
  logic [31:0] e;

  always @(negedge clk) begin
    if (!rst) begin
      if (inst_valid) begin
        if (inst_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_empty: got inst_pc %h expected no instruction", inst_pc);
          end else begin
            e = exp_q.pop_front();
            check("inst_pc", inst_pc, e);
            check("instruction", instruction, mem_word(e));
          end
        end
      end else begin
        check("empty_instruction", instruction, 32'h0);
        check("empty_inst_pc", inst_pc, 32'h0);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input logic rdy, input logic br, input logic cond, input logic jmp,
                       input logic [15:0] imm, input logic [25:0] tgt);
    inst_ready = rdy; BranchSignal = br; BranchCondition = cond;
    Jump = jmp; imm16 = imm; target = tgt;
    if (!rst && rdy && inst_valid) begin
      model_pc = next_pc(model_pc, br, cond, jmp, imm, tgt);
      exp_q.push_back(model_pc);
    end
  endtask

  task automatic rand_apply();
    logic rdy, br, cond, jmp;
    rdy  = ($urandom_range(99, 0) < 70);
    br   = ($urandom_range(99, 0) < 20);
    cond = $urandom_range(1, 0) == 1;
    jmp  = ($urandom_range(99, 0) < 6);
    apply(rdy, br, cond, jmp, 16'($urandom), 26'($urandom));
  endtask

  task automatic do_reset(input logic rdy_after, input logic spur);
    rst = 1'b1;
    apply(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0);
    exp_q.delete();
    model_pc = RESET_PC;
    exp_q.push_back(RESET_PC);
    repeat (3) tick();
    #1;
    check("rst_imem_req", 32'(imem_req), 32'h0);
    check("rst_inst_valid", 32'(inst_valid), 32'h0);
    check("rst_instruction", instruction, 32'h0);
    check("rst_inst_pc", inst_pc, 32'h0);
    force_spur = spur;
    tick();
    rst = 1'b0;
    apply(rdy_after, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0);
    #1;
    force_spur = 1'b0;
  endtask

  int unsigned seen;
  logic        found;

  initial begin
    rst = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    inst_ready = 1'b0; BranchSignal = 1'b0; BranchCondition = 1'b0;
    Jump = 1'b0; imm16 = '0; target = '0;

    // streaming with 1-cycle memory
    lat_min = 1; lat_max = 1; gnt_pct = 100;
    do_reset(1'b1, 1'b0);
    check("c0_req", 32'(imem_req), 32'h1);
    check("c0_addr", imem_addr, 32'h3000);
    tick(); apply(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0); #1;
    check("c1_addr", imem_addr, 32'h3004);
    check("c1_valid", 32'(inst_valid), 32'h0);
    tick(); apply(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0); #1;
    check("c2_valid", 32'(inst_valid), 32'h1);
    check("c2_pc", inst_pc, 32'h3000);
    seen = 0;
    repeat (20) begin
      tick(); apply(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0);
      if (inst_valid) seen++;
    end
    check("no_gaps", seen, 20);

    // jump beats a simultaneous taken branch; penalty with 1-cycle memory
    tick();
    check("pre_jump_valid", 32'(inst_valid), 32'h1);
    apply(1'b1, 1'b1, 1'b1, 1'b1, 16'h0003, 26'h0000C10);
    tick(); apply(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0); #1;
    check("redir_r1_valid", 32'(inst_valid), 32'h0);
    tick(); apply(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0); #1;
    check("redir_r2_valid", 32'(inst_valid), 32'h0);
    tick(); apply(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0); #1;
    check("redir_r3_valid", 32'(inst_valid), 32'h1);
    check("jump_target", inst_pc, 32'h0000_3040);
    repeat (5) begin tick(); apply(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0); end

    // backpressure from reset: credits stop requests at DEPTH
    do_reset(1'b0, 1'b0);
    repeat (10) begin tick(); apply(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0); end
    #1;
    check("bp_fires", fire_cnt, 4);
    check("bp_req", 32'(imem_req), 32'h0);
    check("bp_head", inst_pc, 32'h3000);
    repeat (12) begin tick(); apply(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0); end

    // taken branch at 0x3004 with 3-cycle memory, stale responses in flight
    lat_min = 3; lat_max = 3;
    do_reset(1'b1, 1'b0);
    found = 1'b0;
    for (int unsigned i = 0; i < 30 && !found; i++) begin
      tick();
      if (inst_valid && model_pc == 32'h3004) begin
        apply(1'b1, 1'b1, 1'b1, 1'b0, 16'h0003, 26'h0);
        found = 1'b1;
      end else apply(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0);
    end
    check("branch_issued", 32'(found), 32'h1);
    found = 1'b0;
    for (int unsigned i = 0; i < 20 && !found; i++) begin
      tick(); apply(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0);
      if (inst_valid) begin
        found = 1'b1;
        check("branch_target", inst_pc, 32'h3014);
      end
    end
    check("branch_target_seen", 32'(found), 32'h1);
    repeat (6) begin tick(); apply(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0); end

    // mid-stream reset with a full queue, then a spurious response
    do_reset(1'b0, 1'b0);
    repeat (8) begin tick(); apply(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0); end
    check("pre_reset_valid", 32'(inst_valid), 32'h1);
    do_reset(1'b0, 1'b1);
    check("post_rst_addr", imem_addr, 32'h3000);
    tick(); apply(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0); #1;
    check("spurious_ignored", 32'(inst_valid), 32'h0);
    repeat (10) begin tick(); apply(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0); end

    // randomized traffic, with a reset in the middle
    lat_min = 1; lat_max = 4; gnt_pct = 75;
    do_reset(1'b1, 1'b0);
    for (int unsigned i = 0; i < 4000; i++) begin
      tick();
      if (i == 2000) do_reset(1'b1, 1'b0);
      else rand_apply();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
